// File: rtl/riscv_csr_timer_multi.sv
// Machine timer + CSR block: free-running cycle, prescaled mtime, NUM_CMP compare channels, MIE/MIP/MIEPC.
// CSR response is registered one cycle after csr_valid_i; no backpressure, one access accepted every cycle.
module riscv_csr_timer_multi #(
    parameter int XLEN      = 32,
    parameter int NUM_CMP   = 2,
    parameter int TIMER_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               csr_valid_i,
    input  logic [1:0]         csr_op_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic               csr_rvalid_o,
    output logic               csr_err_o,
    input  logic               irq_taken_i,
    input  logic [XLEN-1:0]    irq_pc_i,
    output logic               timer_tick_o,
    output logic               irq_timer_o,
    output logic [NUM_CMP-1:0] cmp_pending_o
);

    localparam int              PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TIMER_DIV - 1);
    localparam logic [4:0]      NCMP      = 5'(NUM_CMP);
    localparam logic [XLEN-1:0] MIE_MASK  = XLEN'(12'h888);

    localparam logic [1:0] OP_RO = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [11:0] ADDR_CYCLE = 12'h000;
    localparam logic [11:0] ADDR_MTIME = 12'h003;
    localparam logic [11:0] ADDR_MIE   = 12'h005;
    localparam logic [11:0] ADDR_MIEPC = 12'h006;
    localparam logic [11:0] ADDR_MIP   = 12'h007;
    localparam logic [11:0] ADDR_PEND  = 12'h008;
    localparam logic [7:0]  GRP_CMP    = 8'h01;
    localparam logic [7:0]  GRP_CTRL   = 8'h02;
    localparam logic [7:0]  GRP_PERIOD = 8'h03;

    logic [XLEN-1:0]    cycle_q, cycle_d;
    logic [XLEN-1:0]    mtime_q, mtime_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [XLEN-1:0]    mie_q, mie_d;
    logic [XLEN-1:0]    miepc_q, miepc_d;
    logic [NUM_CMP-1:0] pend_q, pend_d;
    logic [XLEN-1:0]    cmp_q    [NUM_CMP];
    logic [XLEN-1:0]    cmp_d    [NUM_CMP];
    logic [XLEN-1:0]    period_q [NUM_CMP];
    logic [XLEN-1:0]    period_d [NUM_CMP];
    logic [1:0]         ctrl_q   [NUM_CMP];
    logic [1:0]         ctrl_d   [NUM_CMP];
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic               tick_q, tick_d;
    logic               irq_q, irq_d;

    logic [7:0]         grp;
    logic [3:0]         idx;
    logic               arr_ok, legal, ro, acc_ok, wr_en, presc_wrap, mtip;
    logic [XLEN-1:0]    old_val, new_val, mip_val;
    logic [NUM_CMP-1:0] en_vec, match;

    assign grp    = csr_addr_i[11:4];
    assign idx    = csr_addr_i[3:0];
    assign arr_ok = ({1'b0, idx} < NCMP) &&
                    ((grp == GRP_CMP) || (grp == GRP_CTRL) || (grp == GRP_PERIOD));

    always_comb begin : status
        mip_val = '0;
        for (int n = 0; n < NUM_CMP; n++) begin
            en_vec[n] = ctrl_q[n][0];
            match[n]  = ctrl_q[n][0] && (mtime_q >= cmp_q[n]);
        end
        mtip       = |(pend_q & en_vec);
        mip_val[7] = mtip;
    end

    always_comb begin : decode
        legal   = arr_ok;
        ro      = 1'b0;
        old_val = '0;
        case (csr_addr_i)
            ADDR_CYCLE: begin legal = 1'b1; ro = 1'b1; old_val = cycle_q; end
            ADDR_MTIME: begin legal = 1'b1; old_val = mtime_q; end
            ADDR_MIE:   begin legal = 1'b1; old_val = mie_q; end
            ADDR_MIEPC: begin legal = 1'b1; old_val = miepc_q; end
            ADDR_MIP:   begin legal = 1'b1; ro = 1'b1; old_val = mip_val; end
            ADDR_PEND:  begin legal = 1'b1; old_val = XLEN'(pend_q); end
            default: ;
        endcase
        for (int n = 0; n < NUM_CMP; n++) begin
            if (arr_ok && (idx == 4'(n))) begin
                case (grp)
                    GRP_CMP:    old_val = cmp_q[n];
                    GRP_CTRL:   old_val = XLEN'(ctrl_q[n]);
                    GRP_PERIOD: old_val = period_q[n];
                    default: ;
                endcase
            end
        end
    end

    // Writes to read-only registers are rejected outright, not silently dropped.
    assign acc_ok = csr_valid_i && legal && !(ro && (csr_op_i != OP_RO));
    assign wr_en  = acc_ok && (csr_op_i != OP_RO);

    always_comb begin : alu
        case (csr_op_i)
            OP_RW:   new_val = csr_wdata_i;
            OP_RS:   new_val = old_val | csr_wdata_i;
            OP_RC:   new_val = old_val & ~csr_wdata_i;
            default: new_val = old_val;
        endcase
    end

    always_comb begin : next_state
        cycle_d    = cycle_q + 1'b1;
        presc_wrap = (presc_q == PRESC_MAX);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        mtime_d    = mtime_q + XLEN'(presc_wrap);
        tick_d     = presc_wrap;
        mie_d      = mie_q;
        miepc_d    = miepc_q;
        pend_d     = pend_q;
        cmp_d      = cmp_q;
        period_d   = period_q;
        ctrl_d     = ctrl_q;

        if (wr_en && (csr_addr_i == ADDR_MTIME)) begin
            mtime_d = new_val;
            presc_d = '0;
            tick_d  = 1'b0;
        end
        if (wr_en && (csr_addr_i == ADDR_MIE))   mie_d   = new_val & MIE_MASK;
        if (wr_en && (csr_addr_i == ADDR_MIEPC)) miepc_d = new_val;
        if (irq_taken_i)                         miepc_d = irq_pc_i;
        if (wr_en && (csr_addr_i == ADDR_PEND))  pend_d  = new_val[NUM_CMP-1:0];

        // Order matters: PEND clear < match set < software CMP write.
        for (int n = 0; n < NUM_CMP; n++) begin
            if (match[n]) begin
                pend_d[n] = 1'b1;
                if (ctrl_q[n][1] && (period_q[n] != '0)) begin
                    cmp_d[n] = cmp_q[n] + period_q[n];
                end
            end
            if (wr_en && (idx == 4'(n))) begin
                case (grp)
                    GRP_CMP: begin
                        cmp_d[n]  = new_val;
                        pend_d[n] = 1'b0;
                    end
                    GRP_CTRL:   ctrl_d[n]   = new_val[1:0];
                    GRP_PERIOD: period_d[n] = new_val;
                    default: ;
                endcase
            end
        end

        rvalid_d = acc_ok;
        err_d    = csr_valid_i && !acc_ok;
        rdata_d  = acc_ok ? old_val : '0;
        irq_d    = mie_q[7] && mtip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q  <= '0;
            mtime_q  <= '0;
            presc_q  <= '0;
            mie_q    <= '0;
            miepc_q  <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= 1'b0;
            irq_q    <= 1'b0;
            for (int n = 0; n < NUM_CMP; n++) begin
                cmp_q[n]    <= '0;
                period_q[n] <= '0;
                ctrl_q[n]   <= '0;
            end
        end else begin
            cycle_q  <= cycle_d;
            mtime_q  <= mtime_d;
            presc_q  <= presc_d;
            mie_q    <= mie_d;
            miepc_q  <= miepc_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            tick_q   <= tick_d;
            irq_q    <= irq_d;
            for (int n = 0; n < NUM_CMP; n++) begin
                cmp_q[n]    <= cmp_d[n];
                period_q[n] <= period_d[n];
                ctrl_q[n]   <= ctrl_d[n];
            end
        end
    end

    assign csr_rdata_o   = rdata_q;
    assign csr_rvalid_o  = rvalid_q;
    assign csr_err_o     = err_q;
    assign timer_tick_o  = tick_q;
    assign irq_timer_o   = irq_q;
    assign cmp_pending_o = pend_q;

endmodule

// File: tb/tb_riscv_csr_timer_multi.sv
// Bench for riscv_csr_timer_multi: one instance with TIMER_DIV=4 (prescaler), one with TIMER_DIV=1 (channels).
// CSR responses are checked by a negedge monitor against a queue of expected responses.
module tb_riscv_csr_timer_multi;

    localparam logic [1:0] RO = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11;
    localparam logic [11:0] A_CYCLE = 12'h000, A_MTIME = 12'h003, A_MIE = 12'h005;
    localparam logic [11:0] A_MIEPC = 12'h006, A_MIP = 12'h007, A_PEND = 12'h008;
    localparam logic [11:0] A_CMP0 = 12'h010, A_CMP1 = 12'h011, A_CTRL0 = 12'h020;
    localparam logic [11:0] A_CTRL1 = 12'h021, A_PER0 = 12'h030, A_PER1 = 12'h031;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_4, rst_1;
    logic        valid_4, valid_1;
    logic [1:0]  op_4, op_1;
    logic [11:0] addr_4, addr_1;
    logic [31:0] wdata_4, wdata_1;
    logic [31:0] rdata_4, rdata_1;
    logic        rvalid_4, rvalid_1, err_4, err_1;
    logic        taken_4, taken_1;
    logic [31:0] pc_4, pc_1;
    logic        tick_4, tick_1, irq_4, irq_1;
    logic [1:0]  pend_4, pend_1;
    logic [31:0] cyc1;

    exp_t q4[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    riscv_csr_timer_multi #(.XLEN(32), .NUM_CMP(2), .TIMER_DIV(4)) u_div4 (
        .clk(clk), .rst_n(rst_4), .csr_valid_i(valid_4), .csr_op_i(op_4),
        .csr_addr_i(addr_4), .csr_wdata_i(wdata_4), .csr_rdata_o(rdata_4),
        .csr_rvalid_o(rvalid_4), .csr_err_o(err_4), .irq_taken_i(taken_4),
        .irq_pc_i(pc_4), .timer_tick_o(tick_4), .irq_timer_o(irq_4),
        .cmp_pending_o(pend_4)
    );

    riscv_csr_timer_multi #(.XLEN(32), .NUM_CMP(2), .TIMER_DIV(1)) u_div1 (
        .clk(clk), .rst_n(rst_1), .csr_valid_i(valid_1), .csr_op_i(op_1),
        .csr_addr_i(addr_1), .csr_wdata_i(wdata_1), .csr_rdata_o(rdata_1),
        .csr_rvalid_o(rvalid_1), .csr_err_o(err_1), .irq_taken_i(taken_1),
        .irq_pc_i(pc_1), .timer_tick_o(tick_1), .irq_timer_o(irq_1),
        .cmp_pending_o(pend_1)
    );

    always #5 clk = ~clk;

    // Reference elapsed-clock count for the TIMER_DIV=1 instance.
    always @(posedge clk or negedge rst_1) begin
        if (!rst_1) cyc1 <= '0;
        else        cyc1 <= cyc1 + 32'd1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic mon_one(input bit d1, input logic rv, input logic er, input logic [31:0] rd);
        exp_t e;
        if ((d1 && q1.size() == 0) || (!d1 && q4.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_resp dut%0d: got rvalid=%0b err=%0b, expected no response",
                     d1 ? 1 : 4, rv, er);
        end else begin
            e = d1 ? q1.pop_front() : q4.pop_front();
            check({e.name, "_err"}, 32'(er), 32'(e.err));
            check({e.name, "_rvalid"}, 32'(rv), 32'(!e.err));
            if (e.chk) check(e.name, rd, e.rdata);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid_4 || err_4) mon_one(1'b0, rvalid_4, err_4, rdata_4);
        if (rvalid_1 || err_1) mon_one(1'b1, rvalid_1, err_1, rdata_1);
    end

    // One CSR access per call; starts and ends #1 after a rising edge.
    task automatic acc(input bit d1, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp, input bit err,
                       input bit chk, input string name);
        exp_t e;
        e.rdata = err ? 32'd0 : exp;
        e.err   = err;
        e.chk   = chk | err;
        e.name  = name;
        if (d1) begin
            valid_1 = 1'b1; op_1 = op; addr_1 = addr; wdata_1 = wd;
            q1.push_back(e);
        end else begin
            valid_4 = 1'b1; op_4 = op; addr_4 = addr; wdata_4 = wd;
            q4.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_1 = 1'b0;
        valid_4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input bit d1, input string tag);
        if (d1) begin
            check({tag, "_rdata"}, rdata_1, 32'd0);
            check({tag, "_rvalid"}, 32'(rvalid_1), 32'd0);
            check({tag, "_err"}, 32'(err_1), 32'd0);
            check({tag, "_tick"}, 32'(tick_1), 32'd0);
            check({tag, "_irq"}, 32'(irq_1), 32'd0);
            check({tag, "_pend"}, 32'(pend_1), 32'd0);
        end else begin
            check({tag, "_rdata"}, rdata_4, 32'd0);
            check({tag, "_rvalid"}, 32'(rvalid_4), 32'd0);
            check({tag, "_err"}, 32'(err_4), 32'd0);
            check({tag, "_tick"}, 32'(tick_4), 32'd0);
            check({tag, "_irq"}, 32'(irq_4), 32'd0);
            check({tag, "_pend"}, 32'(pend_4), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0;
        rst_4 = 1'b0; rst_1 = 1'b0;
        valid_4 = 1'b0; op_4 = RO; addr_4 = '0; wdata_4 = '0; taken_4 = 1'b0; pc_4 = '0;
        valid_1 = 1'b0; op_1 = RO; addr_1 = '0; wdata_1 = '0; taken_1 = 1'b0; pc_1 = '0;

        idle(3);
        chk_zero(1'b0, "rst4");
        chk_zero(1'b1, "rst1");
        @(negedge clk);
        rst_4 = 1'b1;
        rst_1 = 1'b1;

        // Prescaler: tick after every 4th edge, mtime=3 after 12 edges
        for (int k = 1; k <= 12; k++) begin
            idle(1);
            check($sformatf("tick4_edge%0d", k), 32'(tick_4), 32'((k % 4) == 0));
        end
        acc(1'b0, RO, A_MTIME, 0, 32'd3, 0, 1, "mtime4_after12");
        acc(1'b0, RO, A_CYCLE, 0, 32'd13, 0, 1, "cycle4_after13");

        // One-shot on channel 0
        acc(1'b1, RW, A_MTIME, 0, 0, 0, 0, "wr_mtime0");
        acc(1'b1, RW, A_CMP0, 32'd10, 32'd0, 0, 1, "wr_cmp0_10");
        acc(1'b1, RW, A_CTRL0, 32'd1, 32'd0, 0, 1, "wr_ctrl0_1");
        acc(1'b1, RW, A_MIE, 32'h80, 32'd0, 0, 1, "wr_mie_80");
        idle(7);
        check("oneshot_pend_before", 32'(pend_1), 32'd0);
        idle(1);
        check("oneshot_pend_set", 32'(pend_1), 32'd1);
        check("oneshot_irq_not_yet", 32'(irq_1), 32'd0);
        idle(1);
        check("oneshot_irq_set", 32'(irq_1), 32'd1);
        acc(1'b1, RW, A_CMP0, 32'd100, 32'd10, 0, 1, "wr_cmp0_100");
        check("cmpwr_pend_clr", 32'(pend_1), 32'd0);
        check("cmpwr_irq_lag", 32'(irq_1), 32'd1);
        idle(1);
        check("cmpwr_irq_clr", 32'(irq_1), 32'd0);

        // Periodic on channel 1
        acc(1'b1, RW, A_MTIME, 0, 0, 0, 0, "wr_mtime0_b");
        acc(1'b1, RW, A_CMP1, 32'd5, 32'd0, 0, 1, "wr_cmp1_5");
        acc(1'b1, RW, A_PER1, 32'd5, 32'd0, 0, 1, "wr_per1_5");
        acc(1'b1, RW, A_CTRL1, 32'd3, 32'd0, 0, 1, "wr_ctrl1_3");
        idle(3);
        check("periodic_pend1_set", 32'(pend_1), 32'd2);
        acc(1'b1, RO, A_CMP1, 0, 32'd10, 0, 1, "rd_cmp1_10");
        acc(1'b1, RC, A_PEND, 32'h2, 32'h2, 0, 1, "rc_pend_2");
        check("periodic_pend1_clr", 32'(pend_1), 32'd0);
        idle(2);
        check("periodic_pend1_still_clr", 32'(pend_1), 32'd0);
        idle(1);
        check("periodic_pend1_reset", 32'(pend_1), 32'd2);
        acc(1'b1, RO, A_CMP1, 0, 32'd15, 0, 1, "rd_cmp1_15");
        acc(1'b1, RW, A_CTRL1, 32'd0, 32'd3, 0, 1, "wr_ctrl1_0");
        acc(1'b1, RW, A_PEND, 32'd0, 32'h2, 0, 1, "rw_pend_0");

        // CSR op semantics and illegal accesses
        acc(1'b1, RS, A_MIE, 32'hFFFF_FFFF, 32'h80, 0, 1, "rs_mie_all");
        acc(1'b1, RC, A_MIE, 32'h80, 32'h888, 0, 1, "rc_mie_80");
        acc(1'b1, RO, A_MIE, 0, 32'h808, 0, 1, "rd_mie_808");
        acc(1'b1, RW, A_CYCLE, 32'h0, 0, 1, 1, "rw_cycle_err");
        acc(1'b1, RO, A_CYCLE, 0, cyc1, 0, 1, "rd_cycle_intact");
        acc(1'b1, RO, 12'h03F, 0, 0, 1, 1, "rd_03f_err");
        acc(1'b1, RS, 12'h012, 32'h1, 0, 1, 1, "rs_cmp2_err");
        acc(1'b1, RW, A_MIP, 32'h80, 0, 1, 1, "rw_mip_err");
        acc(1'b1, RO, A_PEND, 0, 32'd0, 0, 1, "rd_pend_0");

        // Software CMP write in a reload cycle wins and clears pending
        acc(1'b1, RW, A_MTIME, 0, 0, 0, 0, "wr_mtime0_c");
        acc(1'b1, RW, A_PER0, 32'd4, 32'd0, 0, 1, "wr_per0_4");
        acc(1'b1, RW, A_CMP0, 32'd5, 32'd100, 0, 1, "wr_cmp0_5");
        acc(1'b1, RW, A_CTRL0, 32'd3, 32'd1, 0, 1, "wr_ctrl0_3");
        idle(2);
        acc(1'b1, RW, A_CMP0, 32'd50, 32'd5, 0, 1, "wr_cmp0_in_reload");
        check("collide_cmp_pend0_clr", 32'(pend_1), 32'd0);
        acc(1'b1, RO, A_CMP0, 0, 32'd50, 0, 1, "rd_cmp0_50");

        // PEND clear in a match cycle loses to the set
        acc(1'b1, RW, A_MTIME, 32'd49, 0, 0, 0, "wr_mtime49");
        idle(1);
        acc(1'b1, RC, A_PEND, 32'h1, 32'd0, 0, 1, "rc_pend_in_match");
        check("collide_pend_set_wins", 32'(pend_1), 32'd1);
        acc(1'b1, RS, A_MIE, 32'h80, 32'h808, 0, 1, "rs_mie_80");
        idle(1);
        check("irq_after_mie_set", 32'(irq_1), 32'd1);

        // irq_taken_i beats a software MIEPC write
        taken_1 = 1'b1;
        pc_1 = 32'h100;
        acc(1'b1, RW, A_MIEPC, 32'h200, 32'd0, 0, 1, "wr_miepc_200");
        taken_1 = 1'b0;
        acc(1'b1, RO, A_MIEPC, 0, 32'h100, 0, 1, "rd_miepc_100");

        // mtime wrap
        acc(1'b1, RW, A_MTIME, 32'hFFFF_FFFF, 0, 0, 0, "wr_mtime_max");
        check("wrap_no_tick_on_write", 32'(tick_1), 32'd0);
        acc(1'b1, RO, A_MTIME, 0, 32'hFFFF_FFFF, 0, 1, "rd_mtime_max");
        check("wrap_tick", 32'(tick_1), 32'd1);
        acc(1'b1, RO, A_MTIME, 0, 32'd0, 0, 1, "rd_mtime_wrapped");

        // Asynchronous reset mid-count, then restart from 0
        idle(1);
        #2;
        check("pre_rst_irq", 32'(irq_1), 32'd1);
        check("pre_rst_tick", 32'(tick_1), 32'd1);
        rst_1 = 1'b0;
        #1;
        chk_zero(1'b1, "async_rst");
        @(negedge clk);
        rst_1 = 1'b1;
        idle(1);
        acc(1'b1, RO, A_CYCLE, 0, 32'd1, 0, 1, "cycle_after_rst");
        acc(1'b1, RO, A_MTIME, 0, 32'd2, 0, 1, "mtime_after_rst");
        check("pend_after_rst", 32'(pend_1), 32'd0);

        idle(3);
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_csr_timer_multi.md
Name: riscv_csr_timer_multi

Overview:
- Parametrised machine-timer and CSR block for the RISC-V core.
- Provides a free-running cycle counter, a prescaled mtime, and NUM_CMP independent compare channels. Each channel runs one-shot or periodic (auto-reload).
- Holds MIE/MIP/MIEPC and drives the timer interrupt.
- Sits beside the core's CSR decode stage and is accessed with RW/RS/RC CSR operations.

Parameters:
- XLEN, 32, data width of all counters and CSR data.
- NUM_CMP, 2, number of compare channels (1..16).
- TIMER_DIV, 100000, clocks per mtime tick (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous and active-low.
- csr_valid_i  in  1  CSR access request, one access per cycle.
- csr_op_i  in  2  00 read-only, 01 RW, 10 RS, 11 RC.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  XLEN  write/mask operand.
- csr_rdata_o  out  XLEN  read data (value before the write).
- csr_rvalid_o  out  1  read data valid pulse.
- csr_err_o  out  1  illegal access pulse.
- irq_taken_i  in  1  core is entering the timer trap.
- irq_pc_i  in  XLEN  PC to capture into MIEPC.
- timer_tick_o  out  1  one-cycle pulse when mtime increments.
- irq_timer_o  out  1  machine timer interrupt, level.
- cmp_pending_o  out  NUM_CMP  per-channel pending bits.

Behaviour:
- Reset (asynchronous, immediate): all counters, registers and outputs are 0. cmp[n], period[n] and ctrl[n] are 0.
- Address map:
  - CYCLE 0x000: read-only.
  - MTIME 0x003.
  - MIE 0x005.
  - MIEPC 0x006.
  - MIP 0x007: read-only.
  - PEND 0x008.
  - CMP[n] 0x010+n.
  - CTRL[n] 0x020+n.
  - PERIOD[n] 0x030+n.
- Illegal accesses: an unmapped address, n>=NUM_CMP, or op!=00 to a read-only address. Response: csr_err_o pulses, csr_rdata_o=0, no state change.
- CSR ops: RW new=wdata; RS new=old|wdata; RC new=old&~wdata.
- CSR timing: csr_valid_i is sampled at the edge. csr_rdata_o/csr_rvalid_o/csr_err_o are registered and appear the next cycle; rvalid and err are one-cycle pulses. The write takes effect at the same edge.
- MIE: only bits 3 (MSIE), 7 (MTIE) and 11 (MEIE) are writable; all other bits read 0.
- CTRL[n]: bit0 enable, bit1 periodic; other bits read 0.
- cycle: increments every clock, wraps modulo 2^XLEN.
- Prescaler: counts 0..TIMER_DIV-1. At TIMER_DIV-1 it wraps to 0, mtime increments and timer_tick_o pulses. With TIMER_DIV=1, mtime ticks every cycle.
- mtime write: overrides that cycle's increment and clears the prescaler. mtime wraps 0xFFFF_FFFF -> 0.
- match[n] = ctrl[n].en && (mtime >= cmp[n]), unsigned compare, evaluated each cycle.
- On match[n], pending[n] is set (sticky). If periodic and period[n]!=0, cmp[n] <= cmp[n]+period[n], modulo 2^XLEN. Periodic with period 0 behaves as one-shot.
- pending[n] is cleared by a software write to CMP[n], or by an RC/RW on PEND.
- Simultaneous events:
  - Software write to CMP[n] in a match/reload cycle: the software value wins and pending[n] is cleared.
  - Software clear of PEND in a match cycle: set wins.
  - irq_taken_i together with a software write to MIEPC: irq_taken_i wins.
- Reload wrap: a reload that wraps cmp below mtime re-matches on the next cycle. This is documented software responsibility.
- MIP bit7 = |(pending & en). irq_timer_o = MIE[7] && MIP[7], registered, one cycle after pending sets. cmp_pending_o = pending.
- MIEPC captures irq_pc_i on irq_taken_i.

Test Plan:
- Reset/prescale: TIMER_DIV=4 -> all outputs 0 after rst_n; timer_tick_o every 4th clock; mtime reads 3 after 12 clocks; cycle reads the elapsed clock count.
- One-shot: TIMER_DIV=1, CMP0=10, CTRL0=1, MIE RW 0x80 -> pending0=1 when mtime=10, irq_timer_o=1 the next cycle. Write CMP0=100 -> pending0=0 and irq_timer_o=0 one cycle later.
- Periodic: CMP1=5, PERIOD1=5, CTRL1=3 -> pending1 at mtime 5, CMP1 reads 10. RC PEND 0x2 clears pending1; it sets again at mtime 10 and CMP1 reads 15.
- CSR ops: RS MIE 0xFFFF_FFFF -> reads 0x888; RC MIE 0x80 -> reads 0x808. RW CYCLE -> csr_err_o pulse, cycle unaffected. Read 0x03F with NUM_CMP=2 -> err.
- Collisions: CMP0 write in a reload cycle -> CMP0 holds the written value, pending0=0. RC PEND in a match cycle -> pending stays 1. irq_taken_i with irq_pc_i=0x100 plus MIEPC write 0x200 -> MIEPC reads 0x100.
- Wrap/reset: write MTIME 0xFFFF_FFFF -> next tick reads 0. Assert rst_n mid-count -> outputs 0 with no clock edge; counting resumes from 0 after release.
